// File: rtl/adder_pkg.sv
// adder_pkg: shared width default and prefix-depth helper for the parallel-prefix adders
package adder_pkg;
  localparam int ADD_WIDTH_DEFAULT = 6;
  function automatic int ks_levels(input int width);
    int l = 0;
    while ((1 << l) < width) l++;
    return l;
  endfunction
endpackage

// File: rtl/ks_prefix_cell.sv
// ks_prefix_cell: Kogge-Stone black cell merging a high group with the adjacent low group
module ks_prefix_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g_out,
  output logic p_out
);
  assign g_out = g_hi | (p_hi & g_lo);
  assign p_out = p_hi & p_lo;
endmodule

// File: rtl/kogge_stone_adder_6b.sv
// kogge_stone_adder_6b: registered unsigned adder on a Kogge-Stone carry network, carry-in 0
module kogge_stone_adder_6b
  import adder_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);
  localparam int L = ks_levels(WIDTH);
  logic [L:0][WIDTH-1:0] gs, ps;
  logic [WIDTH-1:0] sum_c;
  logic p_unused;
  assign gs[0] = a & b;
  assign ps[0] = a ^ b;
  for (genvar k = 0; k < L; k++) begin : g_lvl
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= (1 << k)) begin : g_cell
        ks_prefix_cell u_cell (
          .g_hi (gs[k][i]),
          .p_hi (ps[k][i]),
          .g_lo (gs[k][i-(1<<k)]),
          .p_lo (ps[k][i-(1<<k)]),
          .g_out(gs[k+1][i]),
          .p_out(ps[k+1][i])
        );
      end else begin : g_pass
        assign gs[k+1][i] = gs[k][i];
        assign ps[k+1][i] = ps[k][i];
      end
    end
  end
  // group propagates of the final level are never needed once carry-in is 0
  assign p_unused = ^ps[L];
  assign sum_c = ps[0] ^ {gs[L][WIDTH-2:0], 1'b0};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= sum_c;
        cout <= gs[L][WIDTH-1];
      end
    end
  end
endmodule

// File: tb/tb_kogge_stone_adder_6b.sv
// tb_kogge_stone_adder_6b: scoreboard bench for the 6-bit and a 16-bit instance of the adder
module tb_kogge_stone_adder_6b;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic iv6 = 1'b0, ov6, c6;
  logic [5:0] a6 = '0, b6 = '0, s6;
  logic iv16 = 1'b0, ov16, c16;
  logic [15:0] a16 = '0, b16 = '0, s16;
  int total = 0, bad = 0;
  logic [6:0] q6[$];
  logic [16:0] q16[$];
  logic [6:0] e6;
  logic [16:0] e16;
  kogge_stone_adder_6b u_dut6 (
    .clk(clk), .rst(rst), .in_valid(iv6), .a(a6), .b(b6),
    .sum(s6), .cout(c6), .out_valid(ov6)
  );
  kogge_stone_adder_6b #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .a(a16), .b(b16),
    .sum(s16), .cout(c16), .out_valid(ov16)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic drive6(input logic v, input logic [5:0] x, input logic [5:0] y, input logic [6:0] exp);
    @(posedge clk);
    #2;
    iv6 = v;
    a6 = x;
    b6 = y;
    if (v) q6.push_back(exp);
  endtask
  task automatic drive16(input logic v, input logic [15:0] x, input logic [15:0] y, input logic [16:0] exp);
    @(posedge clk);
    #2;
    iv16 = v;
    a16 = x;
    b16 = y;
    if (v) q16.push_back(exp);
  endtask
  always @(posedge clk) begin
    #1;
    if (ov6 === 1'b1) begin
      if (q6.size() == 0) chk("spurious_out6", q6.size(), 1);
      else begin
        e6 = q6.pop_front();
        chk("sum6", s6, e6[5:0]);
        chk("cout6", c6, e6[6]);
      end
    end
    if (ov16 === 1'b1) begin
      if (q16.size() == 0) chk("spurious_out16", q16.size(), 1);
      else begin
        e16 = q16.pop_front();
        chk("sum16", s16, e16[15:0]);
        chk("cout16", c16, e16[16]);
      end
    end
  end
  logic [5:0] ta[8] = '{6'd7, 6'd5, 6'd1, 6'd9, 6'd17, 6'd63, 6'd63, 6'd0};
  logic [5:0] tb[8] = '{6'd7, 6'd5, 6'd3, 6'd7, 6'd6, 6'd1, 6'd63, 6'd0};
  logic [6:0] te[8] = '{7'd14, 7'd10, 7'd4, 7'd16, 7'd23, 7'b1_000000, 7'b1_111110, 7'd0};
  initial begin
    logic [15:0] x, y;
    rst = 1'b0;
    #1 rst = 1'b1;
    #3;
    chk("rst_sum6", s6, 0);
    chk("rst_cout6", c6, 0);
    chk("rst_ov6", ov6, 0);
    chk("rst_ov16", ov16, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 8; i++) drive6(1'b1, ta[i], tb[i], te[i]);
    drive6(1'b1, 6'd20, 6'd10, 7'd30);
    drive6(1'b0, 6'd1, 6'd1, 7'd0);
    @(posedge clk);
    #1;
    chk("hold_ov6", ov6, 0);
    chk("hold_sum6", s6, 30);
    drive6(1'b1, 6'd2, 6'd3, 7'd5);
    drive6(1'b1, 6'd40, 6'd30, 7'b1_000110);
    drive6(1'b0, 6'd0, 6'd0, 7'd0);
    chk("pre_rst_ov6", ov6, 1);
    chk("pre_rst_sum6", s6, 6);
    chk("pre_rst_cout6", c6, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_sum6", s6, 0);
    chk("async_cout6", c6, 0);
    chk("async_ov6", ov6, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++)
        drive6(1'b1, 6'(i), 6'(j), 7'(i + j));
    drive6(1'b0, 6'd0, 6'd0, 7'd0);
    drive16(1'b1, 16'hffff, 16'h0001, 17'h10000);
    drive16(1'b1, 16'h7fff, 16'h0001, 17'h08000);
    drive16(1'b1, 16'hffff, 16'hffff, 17'h1fffe);
    for (int i = 0; i < 500; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      drive16(1'b1, x, y, {1'b0, x} + {1'b0, y});
    end
    drive16(1'b0, 16'd0, 16'd0, 17'd0);
    for (int k = 0; k < 10 && (q6.size() != 0 || q16.size() != 0); k++) @(posedge clk);
    #2;
    chk("drain6", q6.size(), 0);
    chk("drain16", q16.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
